nbit_pipe_addsub: RTL



---
 rtl/nbit_pipe_addsub_pkg.sv | 17 +
 rtl/nbit_pipe_addsub_adder.sv | 14 +
 rtl/nbit_pipe_addsub.sv | 136 +++++++++++++
 3 files changed

// File: rtl/nbit_pipe_addsub_pkg.sv
// rtl/nbit_pipe_addsub_pkg.sv - shared constants and sizing helpers for nbit_pipe_addsub
package nbit_pipe_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Width of one carry chunk; every stage resolves exactly one chunk.
    function automatic int chunk_w(input int n, input int stages);
        return n / stages;
    endfunction

    // Legal split: 1..n stages and the width divides evenly into chunks.
    function automatic bit chunk_fits(input int n, input int stages);
        return (stages >= 1) && (stages <= n) && ((n % stages) == 0);
    endfunction

endpackage

// File: rtl/nbit_pipe_addsub_adder.sv
// rtl/nbit_pipe_addsub_adder.sv - combinational N-bit adder used as one pipeline carry chunk
module nbit_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] s_o,
    output logic         cout_o
);

    assign {cout_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{N{1'b0}}, cin_i};

endmodule

// File: rtl/nbit_pipe_addsub.sv
// rtl/nbit_pipe_addsub.sv - pipelined N-bit add/sub with valid/ready; NBIT_PIPE_ADDSUB_SAT_EN enables signed saturation
module nbit_pipe_addsub
    import nbit_pipe_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         zero
);

    localparam int W = chunk_w(N, STAGES);
    localparam int L = STAGES - 1;

    if (!chunk_fits(N, STAGES)) begin : g_bad_cfg
        $error("nbit_pipe_addsub: N must be a multiple of STAGES and STAGES in 1..N");
    end

    logic                        adv;
    logic [STAGES-1:0]           v_q;
    logic [STAGES-1:0][N-1:0]    a_q, bp_q, res_q;
    logic [STAGES-1:0]           c_q;
    logic [STAGES-1:0][N-1:0]    a_in, bp_in, res_in, res_d;
    logic [STAGES-1:0]           c_in;
    logic [STAGES-1:0][W-1:0]    ch_s;
    logic [STAGES-1:0]           ch_c;
    logic [N-1:0]                s_wrap, s_d;
    logic                        a_msb, bp_msb, ovf_d;
    logic [N-1:0]                s_q;
    logic                        cout_q, ovf_q, zero_q;

    // Whole pipe moves together; a full pipe with a stalled sink freezes everything.
    assign adv = !v_q[L] || out_ready;

    // Stage inputs: stage 0 takes the ports (B inverted and carry forced for subtract),
    // later stages take the skewed operands and partial sum of the previous stage.
    always_comb begin
        a_in[0]   = a;
        bp_in[0]  = (sub == MODE_SUB) ? ~b : b;
        c_in[0]   = (sub == MODE_ADD) ? cin : 1'b1;
        res_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            a_in[k]   = a_q[k-1];
            bp_in[k]  = bp_q[k-1];
            c_in[k]   = c_q[k-1];
            res_in[k] = res_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            res_d[k]            = res_in[k];
            res_d[k][k*W +: W]  = ch_s[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        nbit_adder #(.N(W)) u_chunk (
            .a_i    (a_in[k][k*W +: W]),
            .b_i    (bp_in[k][k*W +: W]),
            .cin_i  (c_in[k]),
            .s_o    (ch_s[k]),
            .cout_o (ch_c[k])
        );
    end

    // Final-stage flags from the completed sum and the operand MSBs carried down the pipe.
    always_comb begin
        s_wrap = res_d[L];
        a_msb  = a_in[L][N-1];
        bp_msb = bp_in[L][N-1];
        ovf_d  = (a_msb == bp_msb) && (s_wrap[N-1] != a_msb);
`ifdef NBIT_PIPE_ADDSUB_SAT_EN
        if (ovf_d) begin
            s_d = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end else begin
            s_d = s_wrap;
        end
`else
        s_d = s_wrap;
`endif
    end

    // Valid bits and result registers: cleared by reset, held while stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            v_q    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            v_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                v_q[k] <= v_q[k-1];
            end
            s_q    <= s_d;
            cout_q <= ch_c[L];
            ovf_q  <= ovf_d;
            zero_q <= (s_d == '0);
        end
    end

    // Operand and partial-sum registers; qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_in[k];
                bp_q[k]  <= bp_in[k];
                c_q[k]   <= ch_c[k];
                res_q[k] <= res_d[k];
            end
        end
    end

    // Last-stage copies and already-consumed low chunks are never read.
    logic unused_q;
    assign unused_q = ^{a_q, bp_q, c_q, res_q};

    assign in_ready  = adv;
    assign out_valid = v_q[L];
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
